// File: rtl/dac8568_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dac8568_request_arbiter
// Purpose  : Merges host DAC writes and eight lock-servo channel updates into
//            one stream of 32-bit DAC8568 frames, offered to the serializer
//            over a valid/ready handshake. Host writes are queued in a small
//            FIFO and always win. Lock updates are coalesced per channel and
//            served round-robin.
// Ports    : clk, reset (sync, active-high)
//            host_cmd/host_data/host_address/host_ready : host write strobe
//            lock_dataN/lock_readyN (N=0..7)            : lock-servo updates
//            out_frame/out_valid/out_ready               : frame handshake
//            host_full, host_overflow, overflow_clear    : FIFO status
//            busy                                        : any work in flight
// Revision : 1.0 - initial release
// ============================================================================
module dac8568_request_arbiter #(
   parameter int         HOST_DEPTH = 4,
   parameter logic [3:0] LOCK_CMD   = 4'h3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  host_cmd,
   input  logic [15:0] host_data,
   input  logic [7:0]  host_address,
   input  logic        host_ready,
   input  logic [15:0] lock_data0,
   input  logic [15:0] lock_data1,
   input  logic [15:0] lock_data2,
   input  logic [15:0] lock_data3,
   input  logic [15:0] lock_data4,
   input  logic [15:0] lock_data5,
   input  logic [15:0] lock_data6,
   input  logic [15:0] lock_data7,
   input  logic        lock_ready0,
   input  logic        lock_ready1,
   input  logic        lock_ready2,
   input  logic        lock_ready3,
   input  logic        lock_ready4,
   input  logic        lock_ready5,
   input  logic        lock_ready6,
   input  logic        lock_ready7,
   output logic [31:0] out_frame,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        host_full,
   output logic        host_overflow,
   input  logic        overflow_clear,
   output logic        busy
);

   localparam int AW = $clog2(HOST_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   state_t state, state_next;

   logic [15:0] lock_data [8];
   logic [7:0]  lock_ready;

   assign lock_data[0] = lock_data0;
   assign lock_data[1] = lock_data1;
   assign lock_data[2] = lock_data2;
   assign lock_data[3] = lock_data3;
   assign lock_data[4] = lock_data4;
   assign lock_data[5] = lock_data5;
   assign lock_data[6] = lock_data6;
   assign lock_data[7] = lock_data7;
   assign lock_ready   = {lock_ready7, lock_ready6, lock_ready5, lock_ready4,
                          lock_ready3, lock_ready2, lock_ready1, lock_ready0};

   // Upper address nibble has no meaning to the DAC8568 frame.
   logic unused_addr_hi;
   assign unused_addr_hi = ^host_address[7:4];

   // Host FIFO: entries are {cmd, addr[3:0], data}
   logic [23:0]   fifo_mem [HOST_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_count;
   logic          fifo_empty, fifo_full;
   logic          fifo_pop, fifo_push, host_drop;

   // Lock slots
   logic [15:0] lock_value [8];
   logic [7:0]  lock_pending;
   logic [7:0]  lock_load;
   logic [2:0]  last_served, rr_sel;
   logic        rr_found;

   logic [31:0] frame_next;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (AW+1)'(HOST_DEPTH));
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign fifo_push  = host_ready & (~fifo_full | fifo_pop);
   assign host_drop  = host_ready & fifo_full & ~fifo_pop;

   // Round-robin search starting just after the last served channel; the
   // last served channel itself is checked last (offset 8 wraps to 0).
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = last_served;
      for (int i = 1; i <= 8; i++) begin
         if (!rr_found && lock_pending[last_served + 3'(i)]) begin
            rr_found = 1'b1;
            rr_sel   = last_served + 3'(i);
         end
      end
   end

   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      lock_load  = '0;
      frame_next = out_frame;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               frame_next = {4'h0, fifo_mem[rd_ptr], 4'h0};
               state_next = ST_OFFER;
            end else if (rr_found) begin
               lock_load[rr_sel] = 1'b1;
               frame_next = {4'h0, LOCK_CMD, 1'b0, rr_sel, lock_value[rr_sel], 4'h0};
               state_next = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_frame     <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         host_overflow <= 1'b0;
         last_served   <= 3'd7;
         lock_pending  <= '0;
         for (int n = 0; n < 8; n++) begin
            lock_value[n] <= '0;
         end
      end else begin
         out_frame <= frame_next;
         if (fifo_push) begin
            fifo_mem[wr_ptr] <= {host_cmd, host_address[3:0], host_data};
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_count <= fifo_count + {{AW{1'b0}}, fifo_push} - {{AW{1'b0}}, fifo_pop};
         // A new drop wins over a simultaneous clear.
         host_overflow <= (host_overflow & ~overflow_clear) | host_drop;
         if (|lock_load) begin
            last_served <= rr_sel;
         end
         // The frame takes the old value; a same-cycle strobe re-arms the slot.
         for (int n = 0; n < 8; n++) begin
            if (lock_ready[n]) begin
               lock_value[n] <= lock_data[n];
            end
         end
         lock_pending <= lock_ready | (lock_pending & ~lock_load);
      end
   end

   assign out_valid = (state == ST_OFFER);
   assign host_full = fifo_full;
   assign busy      = out_valid | ~fifo_empty | (|lock_pending);

endmodule
`default_nettype wire

// File: tb/tb_dac8568_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac8568_request_arbiter
// Purpose  : Self-checking bench for dac8568_request_arbiter. Directed
//            scenarios followed by a randomized run, every cycle compared to
//            a queue/array based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac8568_request_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  host_cmd;
   logic [15:0] host_data;
   logic [7:0]  host_address;
   logic        host_ready;
   logic [15:0] ld [8];
   logic        lr [8];
   logic [31:0] out_frame;
   logic        out_valid;
   logic        out_ready;
   logic        host_full;
   logic        host_overflow;
   logic        overflow_clear;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dac8568_request_arbiter #(.HOST_DEPTH(DEPTH), .LOCK_CMD(4'h3)) dut (
      .clk(clk), .reset(reset),
      .host_cmd(host_cmd), .host_data(host_data),
      .host_address(host_address), .host_ready(host_ready),
      .lock_data0(ld[0]), .lock_data1(ld[1]), .lock_data2(ld[2]), .lock_data3(ld[3]),
      .lock_data4(ld[4]), .lock_data5(ld[5]), .lock_data6(ld[6]), .lock_data7(ld[7]),
      .lock_ready0(lr[0]), .lock_ready1(lr[1]), .lock_ready2(lr[2]), .lock_ready3(lr[3]),
      .lock_ready4(lr[4]), .lock_ready5(lr[5]), .lock_ready6(lr[6]), .lock_ready7(lr[7]),
      .out_frame(out_frame), .out_valid(out_valid), .out_ready(out_ready),
      .host_full(host_full), .host_overflow(host_overflow),
      .overflow_clear(overflow_clear), .busy(busy)
   );

   // Reference model: FIFO as a queue, lock slots as arrays.
   logic [23:0] mq [$];
   logic [15:0] mval [8];
   bit          mpend [8];
   int          mlast;
   bit          mvalid;
   logic [31:0] mframe;
   bit          movf;

   logic [31:0] sent [$];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int  ch;
      bit  anyp;
      if (reset) begin
         mq.delete();
         for (int n = 0; n < 8; n++) begin mval[n] = '0; mpend[n] = 0; end
         mlast = 7; mvalid = 0; mframe = '0; movf = 0;
         return;
      end
      if (mvalid) begin
         if (out_ready) mvalid = 0;
      end else if (mq.size() > 0) begin
         mframe = {4'h0, mq.pop_front(), 4'h0};
         mvalid = 1;
      end else begin
         for (int k = 1; k <= 8; k++) begin
            ch = (mlast + k) % 8;
            if (mpend[ch]) begin
               mframe    = {4'h0, 4'h3, 4'(ch), mval[ch], 4'h0};
               mpend[ch] = 0;
               mlast     = ch;
               mvalid    = 1;
               break;
            end
         end
      end
      if (overflow_clear) movf = 0;
      if (host_ready) begin
         if (mq.size() < DEPTH) mq.push_back({host_cmd, host_address[3:0], host_data});
         else movf = 1;
      end
      for (int n = 0; n < 8; n++) begin
         if (lr[n]) begin mval[n] = ld[n]; mpend[n] = 1; end
      end
      anyp = 0;
      for (int n = 0; n < 8; n++) anyp |= mpend[n];
   endtask

   function automatic bit model_busy();
      bit b = mvalid || (mq.size() > 0);
      for (int n = 0; n < 8; n++) b |= mpend[n];
      return b;
   endfunction

   // One clock: record any transfer, advance the model, check after the edge,
   // then drop all one-cycle strobes.
   task automatic step();
      if (out_valid && out_ready) sent.push_back(out_frame);
      model_step();
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(mvalid));
      check("out_frame", out_frame, mframe);
      check("host_full", 32'(host_full), 32'(mq.size() == DEPTH));
      check("host_overflow", 32'(host_overflow), 32'(movf));
      check("busy", 32'(busy), 32'(model_busy()));
      host_ready = 1'b0; overflow_clear = 1'b0; reset = 1'b0;
      for (int n = 0; n < 8; n++) lr[n] = 1'b0;
   endtask

   task automatic host_write(logic [3:0] c, logic [7:0] a, logic [15:0] d);
      host_cmd = c; host_address = a; host_data = d; host_ready = 1'b1;
   endtask

   initial begin
      reset = 1'b1; host_cmd = '0; host_data = '0; host_address = '0;
      host_ready = 1'b0; out_ready = 1'b0; overflow_clear = 1'b0;
      for (int n = 0; n < 8; n++) begin ld[n] = '0; lr[n] = 1'b0; end
      mlast = 7; mvalid = 0; mframe = '0; movf = 0;
      #2;
      reset = 1'b1; step();
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_frame", out_frame, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // Single host write
      sent.delete();
      out_ready = 1'b1;
      host_write(4'd3, 8'h05, 16'h3355); step();
      check("host_latency_valid", 32'(out_valid), 32'd0);
      step();
      check("host_frame", out_frame, 32'h03533550);
      check("host_frame_valid", 32'(out_valid), 32'd1);
      step();
      check("host_one_cycle", 32'(out_valid), 32'd0);
      check("host_busy_done", 32'(busy), 32'd0);

      // Host beats simultaneous lock
      sent.delete();
      host_write(4'd3, 8'h05, 16'h3355);
      ld[3] = 16'h2233; lr[3] = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("prio_count", 32'(sent.size()), 32'd2);
      if (sent.size() == 2) begin
         check("prio_first", sent[0], 32'h03533550);
         check("prio_second", sent[1], 32'h03322330);
      end

      // Coalescing while host frame is stalled
      sent.delete();
      out_ready = 1'b0;
      host_write(4'd3, 8'h05, 16'h3355); step(); step();
      ld[0] = 16'h2200; lr[0] = 1'b1; step();
      ld[0] = 16'h2211; lr[0] = 1'b1; step();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("coal_count", 32'(sent.size()), 32'd2);
      if (sent.size() == 2) check("coal_frame", sent[1], 32'h03022110);

      // All eight locks after reset: round-robin 0..7
      reset = 1'b1; step();
      sent.delete();
      for (int n = 0; n < 8; n++) begin ld[n] = 16'h1000 + 16'(n); lr[n] = 1'b1; end
      for (int i = 0; i < 20; i++) step();
      check("rr_count", 32'(sent.size()), 32'd8);
      for (int n = 0; n < 8; n++) begin
         if (n < sent.size())
            check($sformatf("rr_ch%0d", n), sent[n], {4'h0, 4'h3, 4'(n), 16'h1000 + 16'(n), 4'h0});
      end

      // FIFO fill and overflow
      sent.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         host_write(4'h2, 8'(i), 16'hA000 + 16'(i)); step();
      end
      check("fill_full", 32'(host_full), 32'd1);
      check("fill_ovf", 32'(host_overflow), 32'd1);
      check("fill_head", out_frame, 32'h020A0000);
      overflow_clear = 1'b1; step();
      check("ovf_clear", 32'(host_overflow), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();
      check("fill_drain_count", 32'(sent.size()), 32'd5);

      // Reset during OFFER with locks pending
      out_ready = 1'b0;
      lr[2] = 1'b1; lr[5] = 1'b1; step(); step();
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      reset = 1'b1; step();
      check("rst_offer_valid", 32'(out_valid), 32'd0);
      check("rst_offer_busy", 32'(busy), 32'd0);
      sent.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("rst_no_frames", 32'(sent.size()), 32'd0);

      // Randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         host_ready = ($urandom_range(0, 2) == 0);
         host_cmd = 4'($urandom()); host_address = 8'($urandom()); host_data = 16'($urandom());
         for (int n = 0; n < 8; n++) begin
            lr[n] = ($urandom_range(0, 4) == 0);
            ld[n] = 16'($urandom());
         end
         out_ready = ($urandom_range(0, 1) == 1);
         overflow_clear = ($urandom_range(0, 19) == 0);
         reset = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
